// File: rtl/eth_tx_framer.sv
// eth_tx_framer: pops raw frames from the TX FIFO and emits preamble, SFD, payload, pad, FCS and IFG
module eth_tx_framer #(
  parameter int MIN_FRAME = 60,
  parameter int IFG_BYTES = 12,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [8:0]       fifo_do,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic             tx_ack,
  output logic [7:0]       tx_data,
  output logic             tx_en,
  output logic             tx_er,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun,
  output logic [CNT_W-1:0] frames_sent,
  output logic [CNT_W-1:0] underruns
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRE   = 3'd1;
  localparam logic [2:0] SFD   = 3'd2;
  localparam logic [2:0] DATA  = 3'd3;
  localparam logic [2:0] PAD   = 3'd4;
  localparam logic [2:0] FCS   = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;
  localparam logic [2:0] IFG   = 3'd7;
  localparam int BW = MIN_FRAME > 0 ? $clog2(MIN_FRAME + 1) : 1;
  localparam logic [BW-1:0] MIN_B = BW'(MIN_FRAME);
  localparam logic [7:0] IFG_LAST = 8'(IFG_BYTES - 1);

  logic [2:0]    state;
  logic [8:0]    hold;
  logic          hold_v, rd_pend, drain;
  logic [31:0]   crc;
  logic [7:0]    cnt;
  logic [BW-1:0] byte_cnt, byte_cnt_n;
  logic [7:0]    fcs_byte;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

  // Byte mux, status flags and FIFO pop decision (prefetch in PRE, next byte on DATA ack, drain in IDLE)
  always_comb begin
    byte_cnt_n = (byte_cnt == MIN_B) ? byte_cnt : byte_cnt + 1'b1;
    fcs_byte = ~crc[{cnt[1:0], 3'b000} +: 8];
    tx_en = state != IDLE && state != IFG;
    tx_er = state == ABORT;
    busy = state != IDLE;
    tx_data = state == PRE ? 8'h55 :
              state == SFD ? 8'hD5 :
              (state == DATA || state == ABORT) ? hold[7:0] :
              state == FCS ? fcs_byte : 8'h00;
    fifo_re = !fifo_empty && ((state == IDLE && drain && !rd_pend) ||
                              (state == PRE && !hold_v && !rd_pend) ||
                              (state == DATA && tx_ack && !hold[8]));
  end

  // Frame sequencer: every state advances on a tx_ack; reads land in hold (or are discarded while draining)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold        <= '0;
      hold_v      <= 1'b0;
      rd_pend     <= 1'b0;
      drain       <= 1'b0;
      crc         <= '1;
      cnt         <= '0;
      byte_cnt    <= '0;
      frame_done  <= 1'b0;
      underrun    <= 1'b0;
      frames_sent <= '0;
      underruns   <= '0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      rd_pend    <= fifo_re;
      if (rd_pend && state == IDLE) drain <= drain & ~fifo_do[8];
      if (rd_pend && state != IDLE) begin
        hold   <= fifo_do;
        hold_v <= 1'b1;
      end
      case (state)
        IDLE: if (!drain && !rd_pend && !fifo_empty) begin
          state <= PRE;
          cnt   <= '0;
        end
        PRE: if (tx_ack) begin
          cnt <= cnt + 1'b1;
          if (cnt == 8'd6) state <= SFD;
        end
        SFD: if (tx_ack) begin
          state    <= DATA;
          crc      <= '1;
          byte_cnt <= '0;
        end
        DATA: if (tx_ack) begin
          crc      <= crc_byte(crc, hold[7:0]);
          hold_v   <= 1'b0;
          byte_cnt <= byte_cnt_n;
          cnt      <= '0;
          if (hold[8]) state <= (byte_cnt_n != MIN_B) ? PAD : FCS;
          else if (fifo_empty) begin
            state     <= ABORT;
            underrun  <= 1'b1;
            underruns <= underruns + 1'b1;
            drain     <= 1'b1;
          end
        end
        PAD: if (tx_ack) begin
          crc      <= crc_byte(crc, 8'h00);
          byte_cnt <= byte_cnt_n;
          if (byte_cnt_n == MIN_B) state <= FCS;
        end
        FCS: if (tx_ack) begin
          cnt <= cnt + 1'b1;
          if (cnt == 8'd3) begin
            state       <= IFG;
            cnt         <= '0;
            frame_done  <= 1'b1;
            frames_sent <= frames_sent + 1'b1;
          end
        end
        ABORT: if (tx_ack) begin
          state <= IFG;
          cnt   <= '0;
        end
        IFG: if (tx_ack) begin
          cnt <= cnt + 1'b1;
          if (cnt == IFG_LAST) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
